// File: rtl/riosub_pkg.sv
// riosub_pkg: shared constants and state types for the riosub receive path.
//   RIOSUB_HDR          frame header word, sent MSB-first
//   RIOSUB_FRAME_BYTES  total bytes per frame (4 header + 4 duty + 1 flags)
//   riosub_state_e      frame parser states
//   uart_state_e        byte receiver states
//   hdr_byte()          header byte at position idx (0 = first on the wire)
package riosub_pkg;

  localparam logic [31:0] RIOSUB_HDR         = 32'h74697277;
  localparam int unsigned RIOSUB_FRAME_BYTES = 9;

  typedef enum logic [1:0] {
    ST_HUNT,
    ST_PAYLOAD,
    ST_CHECK
  } riosub_state_e;

  typedef enum logic [1:0] {
    U_IDLE,
    U_START,
    U_DATA,
    U_STOP
  } uart_state_e;

  function automatic logic [7:0] hdr_byte(input logic [1:0] idx);
    return 8'(RIOSUB_HDR >> {2'd3 - idx, 3'b000});
  endfunction

endpackage

// File: rtl/riosub_uart_rx.sv
// riosub_uart_rx: 8N1 UART byte receiver.
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   rx          serial input, idle high, asynchronous to clk
//   byte_data   last received byte (valid while byte_valid is high)
//   byte_valid  1-clk pulse: byte received with a good stop bit
//   byte_err    1-clk pulse: stop bit sampled low, byte discarded
module riosub_uart_rx
  import riosub_pkg::*;
#(
  parameter int unsigned ClkFrequency = 12000000,
  parameter int unsigned Baud         = 9600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       byte_err
);

  localparam int unsigned CLKS_PER_BIT = ClkFrequency / Baud;
  localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int unsigned CW           = $clog2(CLKS_PER_BIT + 1);

  logic rx_meta, rx_sync, rx_prev;

  uart_state_e state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    bit_idx, bit_idx_n;
  logic [7:0]    shreg, shreg_n;
  logic          valid_n, err_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= U_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      byte_valid <= 1'b0;
      byte_err   <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      bit_idx    <= bit_idx_n;
      shreg      <= shreg_n;
      byte_valid <= valid_n;
      byte_err   <= err_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_idx_n = bit_idx;
    shreg_n   = shreg;
    valid_n   = 1'b0;
    err_n     = 1'b0;
    case (state)
      U_IDLE: begin
        if (rx_prev && !rx_sync) begin
          state_n = U_START;
          cnt_n   = '0;
        end
      end
      U_START: begin
        // Half a bit in: a high line here was a glitch, not a start bit.
        if (cnt == CW'(HALF_BIT - 1)) begin
          cnt_n = '0;
          if (!rx_sync) begin
            state_n   = U_DATA;
            bit_idx_n = '0;
          end else begin
            state_n = U_IDLE;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      U_DATA: begin
        if (cnt == CW'(CLKS_PER_BIT - 1)) begin
          cnt_n   = '0;
          shreg_n = {rx_sync, shreg[7:1]};
          if (bit_idx == 3'd7) state_n = U_STOP;
          else                 bit_idx_n = bit_idx + 3'd1;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      U_STOP: begin
        if (cnt == CW'(CLKS_PER_BIT - 1)) begin
          cnt_n   = '0;
          state_n = U_IDLE;
          if (rx_sync) valid_n = 1'b1;
          else         err_n   = 1'b1;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: state_n = U_IDLE;
    endcase
  end

  assign byte_data = shreg;

endmodule

// File: rtl/riosub_rx.sv
// riosub_rx: receive end of the riosub link. Parses the 9-byte frame
// {header, duty[31:0], {enable, 7'd0}} and presents validated fields atomically.
//   clk             system clock
//   rst_n           asynchronous active-low reset
//   rx              serial line, idle high
//   pwmout2_dty     signed duty from last good frame
//   pwmout2_enable  enable from last good frame, gated by watchdog
//   frame_valid     1-clk pulse when outputs are updated
//   link_ok         high while the watchdog has not expired
//   err_count       saturating count of dropped frames/bytes
module riosub_rx
  import riosub_pkg::*;
#(
  parameter int unsigned ClkFrequency  = 12000000,
  parameter int unsigned Baud          = 9600,
  parameter int unsigned BYTE_TIMEOUT  = 25000,
  parameter int unsigned WATCHDOG_CLKS = 4000000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               rx,
  output logic signed [31:0] pwmout2_dty,
  output logic               pwmout2_enable,
  output logic               frame_valid,
  output logic               link_ok,
  output logic [7:0]         err_count
);

  localparam int unsigned TW = $clog2(BYTE_TIMEOUT + 1);
  localparam int unsigned WW = $clog2(WATCHDOG_CLKS + 1);

  logic [7:0] byte_data;
  logic       byte_valid, byte_err;

  riosub_uart_rx #(
    .ClkFrequency(ClkFrequency),
    .Baud        (Baud)
  ) u_uart (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .byte_data (byte_data),
    .byte_valid(byte_valid),
    .byte_err  (byte_err)
  );

  riosub_state_e state, state_n;
  logic [1:0]    idx, idx_n;
  logic [2:0]    n, n_n;
  logic [39:0]   hold, hold_n;
  logic [TW-1:0] timer;
  logic [WW-1:0] wd;
  logic          en_q;
  logic          hunt0, timeout, pass, err_inc;

  assign hunt0   = (state == ST_HUNT) && (idx == 2'd0);
  // A byte landing on the timeout cycle still counts; the frame survives.
  assign timeout = !hunt0 && (timer == TW'(BYTE_TIMEOUT)) && !byte_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_HUNT;
      idx   <= '0;
      n     <= '0;
      hold  <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      n     <= n_n;
      hold  <= hold_n;
    end
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    n_n     = n;
    hold_n  = hold;
    pass    = 1'b0;
    err_inc = 1'b0;
    case (state)
      ST_HUNT: begin
        if (byte_valid) begin
          if (byte_data == hdr_byte(idx)) begin
            if (idx == 2'd3) begin
              state_n = ST_PAYLOAD;
              idx_n   = '0;
              n_n     = '0;
            end else begin
              idx_n = idx + 2'd1;
            end
          end else begin
            // A stray 0x74 may itself open a new header.
            idx_n = (byte_data == hdr_byte(2'd0)) ? 2'd1 : 2'd0;
          end
        end
      end
      ST_PAYLOAD: begin
        if (byte_valid) begin
          hold_n = {hold[31:0], byte_data};
          if (n == 3'd4) state_n = ST_CHECK;
          else           n_n = n + 3'd1;
        end
      end
      ST_CHECK: begin
        state_n = ST_HUNT;
        idx_n   = '0;
        if (hold[6:0] == 7'd0) pass = 1'b1;
        else                   err_inc = 1'b1;
      end
      default: begin
        state_n = ST_HUNT;
        idx_n   = '0;
      end
    endcase
    if (timeout || byte_err) begin
      state_n = ST_HUNT;
      idx_n   = '0;
      err_inc = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer <= '0;
    end else if (byte_valid || hunt0) begin
      timer <= '0;
    end else if (timer != TW'(BYTE_TIMEOUT)) begin
      timer <= timer + TW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwmout2_dty <= '0;
      en_q        <= 1'b0;
      frame_valid <= 1'b0;
      wd          <= '0;
      err_count   <= '0;
    end else begin
      frame_valid <= pass;
      if (pass) begin
        pwmout2_dty <= signed'(hold[39:8]);
        en_q        <= hold[7];
        wd          <= WW'(WATCHDOG_CLKS);
      end else if (wd != '0) begin
        wd <= wd - WW'(1);
      end
      if (err_inc && (err_count != '1)) err_count <= err_count + 8'd1;
    end
  end

  assign link_ok        = (wd != '0);
  assign pwmout2_enable = en_q & link_ok;

endmodule

// File: tb/tb_riosub_rx.sv
module tb_riosub_rx;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               rx;
  logic signed [31:0] pwmout2_dty;
  logic               pwmout2_enable;
  logic               frame_valid;
  logic               link_ok;
  logic [7:0]         err_count;

  int total = 0;
  int bad   = 0;
  int fv_count = 0;
  int cyc = 0;
  int last_fv_cyc = 0;

  always #5 clk = ~clk;

  riosub_rx #(
    .ClkFrequency (1000000),
    .Baud         (100000),
    .BYTE_TIMEOUT (300),
    .WATCHDOG_CLKS(5000)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rx            (rx),
    .pwmout2_dty   (pwmout2_dty),
    .pwmout2_enable(pwmout2_enable),
    .frame_valid   (frame_valid),
    .link_ok       (link_ok),
    .err_count     (err_count)
  );

  always @(posedge clk) cyc = cyc + 1;

  always @(negedge clk) begin
    if (frame_valid) begin
      fv_count    = fv_count + 1;
      last_fv_cyc = cyc;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total = total + 1;
    if (got !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic idle(input int clks);
    rx = 1'b1;
    repeat (clks) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(negedge clk);
    rx = 1'b0;
    repeat (10) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (10) @(negedge clk);
    end
    rx = stop;
    repeat (10) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic send_hdr();
    send_byte(8'h74, 1'b1);
    send_byte(8'h69, 1'b1);
    send_byte(8'h72, 1'b1);
    send_byte(8'h77, 1'b1);
  endtask

  task automatic send_frame(input logic [31:0] d, input logic en, input logic [6:0] rsv);
    send_hdr();
    send_byte(d[31:24], 1'b1);
    send_byte(d[23:16], 1'b1);
    send_byte(d[15:8], 1'b1);
    send_byte(d[7:0], 1'b1);
    send_byte({en, rsv}, 1'b1);
  endtask

  task automatic check_out(input string tag, input logic [31:0] dty, input logic en,
                           input logic lok, input logic [7:0] errs, input int fvs);
    check_val({tag, "_dty"}, pwmout2_dty, dty);
    check_val({tag, "_en"}, 32'(pwmout2_enable), 32'(en));
    check_val({tag, "_link"}, 32'(link_ok), 32'(lok));
    check_val({tag, "_err"}, 32'(err_count), 32'(errs));
    check_val({tag, "_fvcnt"}, 32'(fv_count), 32'(fvs));
  endtask

  initial begin
    rx    = 1'b1;
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    check_out("reset", 32'd0, 1'b0, 1'b0, 8'd0, 0);
    check_val("reset_fv", 32'(frame_valid), 32'd0);
    rst_n = 1'b1;
    idle(20);

    // 1: basic frame
    send_frame(32'd500, 1'b1, 7'd0);
    idle(5);
    check_out("t1", 32'd500, 1'b1, 1'b1, 8'd0, 1);
    check_val("t1_fv_low", 32'(frame_valid), 32'd0);

    // 2: leading junk 0x74 resyncs onto header
    send_byte(8'h74, 1'b1);
    send_frame(32'hFFFFFF9C, 1'b0, 7'd0);
    idle(5);
    check_out("t2", 32'hFFFFFF9C, 1'b0, 1'b1, 8'd0, 2);

    // 3: reserved bit set in last byte
    send_frame(32'h11111111, 1'b1, 7'h01);
    idle(5);
    check_out("t3", 32'hFFFFFF9C, 1'b0, 1'b1, 8'd1, 2);

    // 4: inter-byte timeout, then a good frame
    send_hdr();
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    idle(400);
    check_val("t4_timeout_err", 32'(err_count), 32'd2);
    check_val("t4_timeout_dty", pwmout2_dty, 32'hFFFFFF9C);
    send_frame(32'd7, 1'b1, 7'd0);
    idle(5);
    check_out("t4", 32'd7, 1'b1, 1'b1, 8'd2, 3);

    // 5: framing error mid-payload, then a good frame
    send_hdr();
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b1);
    send_byte(8'h56, 1'b0);
    idle(20);
    check_out("t5_drop", 32'd7, 1'b1, 1'b1, 8'd3, 3);
    send_frame(32'h12345678, 1'b1, 7'd0);
    idle(5);
    check_out("t5", 32'h12345678, 1'b1, 1'b1, 8'd3, 4);

    // 6: watchdog expiry, measured from the frame_valid pulse
    while (cyc < last_fv_cyc + 4990) @(negedge clk);
    check_val("t6_link_before", 32'(link_ok), 32'd1);
    check_val("t6_en_before", 32'(pwmout2_enable), 32'd1);
    while (cyc < last_fv_cyc + 5010) @(negedge clk);
    check_out("t6_expired", 32'h12345678, 1'b0, 1'b0, 8'd3, 4);

    // asynchronous reset mid-frame
    send_hdr();
    send_byte(8'hAA, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_out("t6_rst", 32'd0, 1'b0, 1'b0, 8'd0, 4);
    check_val("t6_rst_fv", 32'(frame_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(20);
    send_frame(32'd9, 1'b1, 7'd0);
    idle(5);
    check_out("t6_recover", 32'd9, 1'b1, 1'b1, 8'd0, 5);

    // err_count saturation via repeated framing errors at hunt
    for (int k = 0; k < 258; k++) begin
      send_byte(8'h00, 1'b0);
      idle(3);
    end
    check_val("sat_err", 32'(err_count), 32'h000000FF);
    check_val("sat_dty", pwmout2_dty, 32'd9);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
